hls_deadlock_reporter: RTL and testbench
========================================

# hls_deadlock_reporter

Receive-side companion to the per-dataflow deadlock monitors. It collects the `block` outputs of up to NUM_MON monitors and confirms a deadlock only when blocking persists for THRESHOLD consecutive cycles, so one-cycle detector flicker is ignored. On confirmation it latches which monitors fired and a timestamp, presents a single report over a valid/ready handshake, and holds a sticky `deadlock` flag until software clears it. It sits between the monitor instances and the debug/status register path of the top-level kernel wrapper.

## Interface
- NUM_MON, 4, number of monitor `block` inputs (1..32)
- CNT_W, 16, width of free-running timestamp and persistence counter
- THRESHOLD, 64, consecutive blocked cycles required to confirm (2..2^CNT_W-1)
- clock  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low (reset==0 resets on next rising edge)
- enable  in  1  arms detection; low forces the reporter to stay in or return to IDLE from COUNT
- block_in  in  NUM_MON  registered `block` outputs of the monitors
- clear  in  1  one-cycle pulse: drops the sticky flag and returns the reporter to IDLE
- report_valid  out  1  report payload valid
- report_ready  in  1  consumer accepts the report
- report_mask  out  NUM_MON  OR of every block_in sample taken during the confirming window
- report_stamp  out  CNT_W  timestamp value on the first blocked sample of the window
- deadlock  out  1  sticky confirmed-deadlock flag
- event_count  out  8  number of accepted reports, saturates at 255

## Operation
- Free-running timestamp `ts`:
  - reset to 0, increments every cycle and wraps at 2^CNT_W.
- FSM states are IDLE, COUNT, REPORT and HOLD. `any = |block_in`.
- IDLE:
  - if enable & any: go to COUNT, cnt<=1, mask<=block_in, stamp<=ts.
  - otherwise cnt<=0.
- COUNT:
  - if !any or !enable: go to IDLE, cnt<=0, mask<=0.
  - otherwise mask<=mask|block_in.
  - if cnt==THRESHOLD-1: go to REPORT. Otherwise cnt<=cnt+1.
  - Any gap in blocking restarts the window. A fresh stamp is taken on the next blocked sample.
- REPORT:
  - report_valid=1. report_mask and report_stamp are frozen.
  - deadlock=1 from REPORT entry.
  - on report_ready: go to HOLD, event_count<=sat(event_count+1).
  - block_in and enable are ignored.
- HOLD:
  - report_valid=0, deadlock stays 1, block_in is ignored.
  - on clear: go to IDLE.
- clear priority:
  - clear in any state forces IDLE and deadlock<=0 on the next edge, overriding every other transition.
  - clear in REPORT while report_ready=1 aborts the report. event_count is not incremented.
  - clear in IDLE or COUNT also zeroes cnt and mask.
- Reset values:
  - state=IDLE; report_valid=0, report_mask=0, report_stamp=0, deadlock=0, event_count=0, ts=0, cnt=0.
- report_mask and report_stamp outputs:
  - driven from holding registers and valid whenever report_valid=1.
  - in HOLD they keep the last report.
  - cleared to 0 on clear or reset.
- reset asserted mid-operation, including during REPORT with valid high, returns all of the above to reset values on that edge. No report is completed.

## Timing
- block_in is sampled directly with no input register. The monitors already register their outputs.
- Confirmation latency, when enable stays high:
  - let edge t be the first edge where IDLE samples any=1.
  - the THRESHOLD-th consecutive blocked sample is at edge t+THRESHOLD-1.
  - report_valid and deadlock rise after that edge, i.e. THRESHOLD cycles after the first blocked sample.
- Handshake: a transfer occurs on an edge with report_valid & report_ready. report_valid drops after that edge. At most one report is issued per clear.
- report_valid never deasserts without a transfer, except on clear or reset.
- event_count updates on the transfer edge.
- deadlock stays high from REPORT entry until the edge sampling clear=1, then reads 0 on the following cycle.
- Timestamp wrap is not special-cased. report_stamp is the raw ts value.

## Test plan
- THRESHOLD=4, block_in=4'b0001 held from cycle 10 (ts=10) with enable high → report_valid rises at cycle 14, report_mask=0001, report_stamp=10, deadlock=1.
- block_in toggles 0001 for 3 cycles, then 0000 for 1 cycle, then 0010 held, starting at ts=20 → no report for the first burst. Report_stamp=24, report_mask=0010, valid 4 cycles after ts=24.
- Blocked window with 0001, 0011, 0100 across cycles, report_ready held low for 10 cycles then pulsed → report_mask=0111 and stable while valid. Valid drops after the ready edge, event_count=1, deadlock stays 1 in HOLD.
- clear pulsed in HOLD, then block held again → deadlock=0 on the cycle after clear. A second report appears after THRESHOLD more cycles; accepting it gives event_count=2.
- clear and report_ready high on the same edge in REPORT → IDLE, report_valid=0, deadlock=0, event_count unchanged. reset=0 during COUNT → all outputs 0 next cycle.
- enable low with block held → no report. Raising enable starts the window on the first enabled sample. event_count at 255 plus one more accepted report → stays 255.

Source files
------------

// File: rtl/hls_deadlock_reporter.sv
// rtl/hls_deadlock_reporter.sv - confirms persistent monitor blocking and reports it once
// A window of THRESHOLD consecutive enabled blocked samples confirms a deadlock; the report is held until clear.
module hls_deadlock_reporter #(
  parameter int NUM_MON   = 4,
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] block_in,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [NUM_MON-1:0] report_mask,
  output logic [CNT_W-1:0]   report_stamp,
  output logic               deadlock,
  output logic [7:0]         event_count
);

  typedef enum logic [1:0] {IDLE, COUNT, REPORT, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] ts;
  logic [CNT_W-1:0] cnt;
  logic             any;

  assign any = |block_in;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      ts           <= '0;
      cnt          <= '0;
      report_valid <= 1'b0;
      report_mask  <= '0;
      report_stamp <= '0;
      deadlock     <= 1'b0;
      event_count  <= 8'd0;
    end else begin
      ts <= ts + CNT_W'(1);
      // clear overrides every transition, including a same-edge report handshake
      if (clear) begin
        state        <= IDLE;
        cnt          <= '0;
        report_valid <= 1'b0;
        report_mask  <= '0;
        report_stamp <= '0;
        deadlock     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (enable && any) begin
              state        <= COUNT;
              cnt          <= CNT_W'(1);
              report_mask  <= block_in;
              report_stamp <= ts;
            end else begin
              cnt <= '0;
            end
          end
          COUNT: begin
            if (!enable || !any) begin
              state       <= IDLE;
              cnt         <= '0;
              report_mask <= '0;
            end else begin
              report_mask <= report_mask | block_in;
              if (cnt == LAST) begin
                state        <= REPORT;
                report_valid <= 1'b1;
                deadlock     <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          REPORT: begin
            if (report_ready) begin
              state        <= HOLD;
              report_valid <= 1'b0;
              if (event_count != 8'hFF) event_count <= event_count + 8'd1;
            end
          end
          HOLD: begin
            state <= HOLD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// tb/tb_hls_deadlock_reporter.sv - vector table, corner sequences and random run against a reference model
module tb_hls_deadlock_reporter;

  localparam int NM  = 4;
  localparam int CW  = 16;
  localparam int THR = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [NM-1:0] block_in;
  logic          clear;
  logic          report_valid;
  logic          report_ready;
  logic [NM-1:0] report_mask;
  logic [CW-1:0] report_stamp;
  logic          deadlock;
  logic [7:0]    event_count;

  hls_deadlock_reporter #(.NUM_MON(NM), .CNT_W(CW), .THRESHOLD(THR)) dut (
    .clock(clock), .reset(reset), .enable(enable), .block_in(block_in), .clear(clear),
    .report_valid(report_valid), .report_ready(report_ready), .report_mask(report_mask),
    .report_stamp(report_stamp), .deadlock(deadlock), .event_count(event_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: phase 0 = waiting/accumulating, 1 = report offered, 2 = report taken
  int            m_phase, m_run, m_ev;
  logic [NM-1:0] m_mask;
  logic [CW-1:0] m_stamp, m_ts;
  logic          m_dl;
  logic          m_defined;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic en, input logic [NM-1:0] blk, input logic clr,
                            input logic rdy, input logic rst);
    logic [CW-1:0] now;
    if (!rst) begin
      m_ts = '0; m_phase = 0; m_run = 0; m_mask = '0; m_stamp = '0;
      m_dl = 1'b0; m_ev = 0; m_defined = 1'b1;
    end else begin
      now  = m_ts;
      m_ts = m_ts + 16'd1;
      if (clr) begin
        m_phase = 0; m_run = 0; m_mask = '0; m_stamp = '0; m_dl = 1'b0; m_defined = 1'b1;
      end else if (m_phase == 0) begin
        if (en && blk != '0) begin
          if (m_run == 0) begin
            m_stamp = now; m_mask = '0; m_defined = 1'b0;
          end
          m_mask = m_mask | blk;
          m_run++;
          if (m_run == THR) begin
            m_phase = 1; m_dl = 1'b1; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (m_phase == 1 && rdy) begin
        m_phase = 2;
        if (m_ev < 255) m_ev++;
      end
    end
  endtask

  task automatic tick(input logic en, input logic [NM-1:0] blk, input logic clr,
                      input logic rdy, input logic rst);
    enable = en; block_in = blk; clear = clr; report_ready = rdy; reset = rst;
    model_step(en, blk, clr, rdy, rst);
    @(posedge clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, int'(report_valid), int'(m_phase == 1));
    chk({tag, ".deadlock"}, int'(deadlock), int'(m_dl));
    chk({tag, ".events"}, int'(event_count), m_ev);
    if (m_phase != 0 || m_defined) begin
      chk({tag, ".mask"}, int'(report_mask), int'(m_mask));
      chk({tag, ".stamp"}, int'(report_stamp), int'(m_stamp));
    end
  endtask

  typedef struct {
    logic          en;
    logic [NM-1:0] blk;
    logic          clr;
    logic          rdy;
    logic          v;
    logic          dl;
    int            m;   // -1: not checked
    int            s;   // -1: not checked
    int            ev;
  } row_t;

  row_t rows[24];

  function automatic row_t mk(input logic en, input logic [NM-1:0] blk, input logic clr,
                              input logic rdy, input logic v, input logic dl,
                              input int m, input int s, input int ev);
    row_t r;
    r.en = en; r.blk = blk; r.clr = clr; r.rdy = rdy;
    r.v = v; r.dl = dl; r.m = m; r.s = s; r.ev = ev;
    return r;
  endfunction

  initial begin
    logic [NM-1:0] rb;
    int r;

    // Row i is sampled on the edge where ts == i
    rows[0]  = mk(1, 4'b0000, 0, 0, 0, 0,  0,  0, 0);
    rows[1]  = mk(1, 4'b0001, 0, 0, 0, 0, -1, -1, 0);
    rows[2]  = mk(1, 4'b0011, 0, 0, 0, 0, -1, -1, 0);
    rows[3]  = mk(1, 4'b0000, 0, 0, 0, 0, -1, -1, 0);
    rows[4]  = mk(1, 4'b0100, 0, 0, 0, 0, -1, -1, 0);
    rows[5]  = mk(1, 4'b0001, 0, 0, 0, 0, -1, -1, 0);
    rows[6]  = mk(1, 4'b0010, 0, 0, 0, 0, -1, -1, 0);
    rows[7]  = mk(1, 4'b0100, 0, 0, 1, 1,  7,  4, 0);
    rows[8]  = mk(0, 4'b1111, 0, 0, 1, 1,  7,  4, 0);
    rows[9]  = mk(1, 4'b1111, 0, 1, 0, 1,  7,  4, 1);
    rows[10] = mk(1, 4'b1111, 0, 1, 0, 1,  7,  4, 1);
    rows[11] = mk(1, 4'b0000, 1, 0, 0, 0,  0,  0, 1);
    rows[12] = mk(1, 4'b0001, 0, 0, 0, 0, -1, -1, 1);
    rows[13] = mk(1, 4'b0001, 0, 0, 0, 0, -1, -1, 1);
    rows[14] = mk(1, 4'b0001, 0, 0, 0, 0, -1, -1, 1);
    rows[15] = mk(1, 4'b0001, 0, 0, 1, 1,  1, 12, 1);
    rows[16] = mk(1, 4'b0001, 1, 1, 0, 0,  0,  0, 1);
    rows[17] = mk(0, 4'b0001, 0, 0, 0, 0,  0,  0, 1);
    rows[18] = mk(0, 4'b0011, 0, 0, 0, 0,  0,  0, 1);
    rows[19] = mk(1, 4'b0010, 0, 0, 0, 0, -1, -1, 1);
    rows[20] = mk(1, 4'b0010, 0, 0, 0, 0, -1, -1, 1);
    rows[21] = mk(1, 4'b0010, 0, 0, 0, 0, -1, -1, 1);
    rows[22] = mk(1, 4'b0010, 0, 0, 1, 1,  2, 19, 1);
    rows[23] = mk(1, 4'b0010, 0, 1, 0, 1,  2, 19, 2);

    enable = 0; block_in = '0; clear = 0; report_ready = 0; reset = 0;
    tick(0, '0, 0, 0, 0);
    tick(1, 4'b1111, 0, 1, 0);
    chk("rst.valid", int'(report_valid), 0);
    chk("rst.deadlock", int'(deadlock), 0);
    chk("rst.mask", int'(report_mask), 0);
    chk("rst.stamp", int'(report_stamp), 0);
    chk("rst.events", int'(event_count), 0);

    for (int i = 0; i < 24; i++) begin
      tick(rows[i].en, rows[i].blk, rows[i].clr, rows[i].rdy, 1);
      chk($sformatf("row%0d.valid", i), int'(report_valid), int'(rows[i].v));
      chk($sformatf("row%0d.deadlock", i), int'(deadlock), int'(rows[i].dl));
      chk($sformatf("row%0d.events", i), int'(event_count), rows[i].ev);
      if (rows[i].m >= 0) chk($sformatf("row%0d.mask", i), int'(report_mask), rows[i].m);
      if (rows[i].s >= 0) chk($sformatf("row%0d.stamp", i), int'(report_stamp), rows[i].s);
    end

    // Reset mid-window wipes everything on that edge
    tick(1, 4'b0001, 0, 0, 1);
    tick(1, 4'b0001, 0, 0, 1);
    tick(1, 4'b0001, 0, 1, 0);
    chk("midrst.valid", int'(report_valid), 0);
    chk("midrst.mask", int'(report_mask), 0);
    chk("midrst.events", int'(event_count), 0);
    chk("midrst.deadlock", int'(deadlock), 0);

    // Reset while a report is offered: the report is never completed
    for (int i = 0; i < THR; i++) tick(1, 4'b1000, 0, 0, 1);
    chk("pre_rst_report.valid", int'(report_valid), 1);
    tick(1, 4'b1000, 0, 1, 0);
    chk("rst_in_report.valid", int'(report_valid), 0);
    chk("rst_in_report.events", int'(event_count), 0);
    chk("rst_in_report.stamp", int'(report_stamp), 0);

    // Event counter saturation over 260 accepted reports
    for (int k = 0; k < 260; k++) begin
      tick(1, '0, 1, 0, 1);
      for (int i = 0; i < THR; i++) tick(1, 4'b0110, 0, 0, 1);
      tick(1, 4'b0110, 0, 1, 1);
      if (k == 253) chk("sat.254", int'(event_count), 254);
      if (k == 254) chk("sat.255", int'(event_count), 255);
    end
    chk("sat.final", int'(event_count), 255);
    chk("sat.hold_deadlock", int'(deadlock), 1);
    chk("sat.hold_valid", int'(report_valid), 0);
    check_model("sat");

    // Randomized traffic against the model
    tick(0, '0, 0, 0, 0);
    rb = 4'b0001;
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) rb = '0;
      else if (r == 1) rb = NM'($urandom);
      tick($urandom_range(0, 15) != 0, rb, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 299) != 0);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
